uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Round-robin arbiter that shares the single UART transmit user interface among several byte-stream requesters: a loopback FIFO path, a status reporter, a debug dumper, and so on. It sits between the requesters and the UART driver's `i_user_tx_data` / `i_user_tx_data_vaild` / `o_user_tx_data_ready` port, in the UART user clock domain. Arbitration is frame-locked: once a requester is granted, it keeps the transmitter until it sends a byte marked last, or until it stalls longer than a gap timeout.

## Interface
- `P_REQ_NUM`, default 4: number of requesters, 2..8.
- `P_UART_DATA_WIDTH`, default 8: byte width.
- `P_GAP_TIMEOUT`, default 50000: idle user-clock cycles tolerated mid-frame before the grant is revoked. Minimum 2.

Ports (reset `w_user_rst`, asynchronous, active-high; clock `w_user_clk`):
- `w_user_clk`, in, 1: UART user clock.
- `w_user_rst`, in, 1: asynchronous active-high reset.
- `i_req_data`, in, `P_REQ_NUM*P_UART_DATA_WIDTH`: requester k's byte is at `[k*W +: W]`.
- `i_req_valid`, in, `P_REQ_NUM`: per-requester byte valid.
- `i_req_last`, in, `P_REQ_NUM`: byte is the final byte of the frame; qualified by valid.
- `o_req_ready`, out, `P_REQ_NUM`: byte accepted when `valid & ready`.
- `o_tx_data`, out, `P_UART_DATA_WIDTH`: byte to the UART driver.
- `o_tx_valid`, out, 1: one-cycle send strobe to the UART driver.
- `i_tx_ready`, in, 1: UART driver idle (level); drops while a byte is shifting out.
- `o_grant`, out, `P_REQ_NUM`: one-hot current owner; all zero when idle.
- `o_busy`, out, 1: state ≠ IDLE.
- `o_frame_abort`, out, 1: one-cycle pulse when a grant is revoked by gap timeout.

## Operation
- **Reset values.** All outputs are 0. State is IDLE. The round-robin pointer `r_last` is `P_REQ_NUM-1`, so requester 0 has highest priority first. The gap counter is 0.
- **IDLE.**
  - If any `i_req_valid` is set, pick the first requester scanning from `r_last+1` with wrap-around.
  - Register the winner one-hot into `o_grant` and go to FETCH.
- **FETCH.**
  - `o_req_ready[g] = i_req_valid[g]` (combinational); all other ready bits are 0.
  - On handshake: capture the data into `o_tx_data`, capture last into `r_last_flag`, clear the gap counter, and go to ISSUE.
  - Without a handshake: increment the gap counter, saturating.
  - When the gap counter reaches `P_GAP_TIMEOUT-1` with no handshake:
    - pulse `o_frame_abort`;
    - set `r_last` to g and clear `o_grant`;
    - go to IDLE.
- **ISSUE.** `o_tx_valid = i_tx_ready` (combinational). When it is 1, go to WAIT_LOW.
- **WAIT_LOW.** Wait for `i_tx_ready==0`, meaning the driver has taken the byte, then go to WAIT_HIGH.
- **WAIT_HIGH.** Wait for `i_tx_ready==1`. Then:
  - if `r_last_flag` is set: `r_last` is set to g, `o_grant` is cleared, go to IDLE;
  - otherwise go to FETCH, grant held.
- **Invariants.**
  - Only one byte is outstanding at a time.
  - Non-granted requesters never see ready.
  - `o_tx_data` is stable from capture until the next capture.
- **Reset mid-operation.** Any state returns to reset values immediately. A byte already handed to the driver is the driver's concern; the arbiter issues nothing further.
- **`i_req_last` on abort.** The abort path ignores `i_req_last`.

## Timing
- Latency from IDLE with a valid requester at cycle 0 (tx idle):
  - cycle 1: `o_grant` valid and `o_req_ready` high;
  - cycle 2: `o_tx_valid` high.
- The byte after a non-last byte is accepted in the cycle following the `i_tx_ready` rise (FETCH). `o_tx_valid` follows one cycle later.
- Overhead between bytes of one frame is 2 cycles beyond the UART character time.
- Rearbitration costs 1 IDLE cycle between frames.
- A requester asserting valid while another owns the grant waits. No starvation: the maximum wait is `P_REQ_NUM-1` frames.
- The gap timeout counts FETCH cycles only. Waiting on the UART never times out.

## Test plan
- **Single frame.** Requester 2 sends 3 bytes 0xA1, 0xA2, 0xA3, with last set on 0xA3. Required:
  - `o_grant=4'b0100` throughout;
  - three `o_tx_valid` strobes carrying 0xA1, 0xA2, 0xA3 in order;
  - each strobe only while `i_tx_ready=1`;
  - `o_grant` returns to 0 after the final `i_tx_ready` rise.
- **Round robin.** Requesters 0, 1 and 3 all hold single-byte frames (0x10, 0x11, 0x13) from reset. Required: output order 0x10, 0x11, 0x13. Then requester 0 is re-armed while 3 owns the grant; required: it is served next.
- **Frame lock.** Requester 1 starts a 4-byte frame. Requester 0 asserts valid after byte 1. Required: all 4 bytes of requester 1 are sent before any byte of requester 0, and `o_req_ready[0]` stays 0 during that time.
- **Gap timeout** (`P_GAP_TIMEOUT=8`). Requester 0 sends one non-last byte, then drops valid. Required:
  - `o_frame_abort` pulses exactly once, 8 FETCH cycles after entry;
  - the grant clears;
  - a pending requester 1 is granted next.
- **Slow ready.** The model holds `i_tx_ready` low for 100 cycles after each strobe. Required: exactly one `o_tx_valid` per byte, and no strobe while ready is low.
- **Reset mid-frame.** Assert `w_user_rst` in WAIT_LOW. Required: all outputs 0 asynchronously; after release, requester 0 has priority and a new frame sends correctly.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: frame-locked round-robin arbiter that shares one UART
// transmit user interface among several byte-stream requesters. A granted
// requester keeps the transmitter until it sends a byte marked last, or until
// it leaves the arbiter waiting for a byte longer than the gap timeout.
module uart_tx_arbiter #(
  parameter int P_REQ_NUM         = 4,
  parameter int P_UART_DATA_WIDTH = 8,
  parameter int P_GAP_TIMEOUT     = 50000
) (
  input  logic                                   w_user_clk,
  input  logic                                   w_user_rst,
  input  logic [P_REQ_NUM*P_UART_DATA_WIDTH-1:0] i_req_data,
  input  logic [P_REQ_NUM-1:0]                   i_req_valid,
  input  logic [P_REQ_NUM-1:0]                   i_req_last,
  output logic [P_REQ_NUM-1:0]                   o_req_ready,
  output logic [P_UART_DATA_WIDTH-1:0]           o_tx_data,
  output logic                                   o_tx_valid,
  input  logic                                   i_tx_ready,
  output logic [P_REQ_NUM-1:0]                   o_grant,
  output logic                                   o_busy,
  output logic                                   o_frame_abort
);

  localparam int IDX_W = (P_REQ_NUM > 1) ? $clog2(P_REQ_NUM) : 1;
  localparam int GAP_W = (P_GAP_TIMEOUT > 1) ? $clog2(P_GAP_TIMEOUT) : 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_ISSUE,
    ST_WAIT_LOW,
    ST_WAIT_HIGH
  } state_t;

  state_t                         r_state;
  logic [IDX_W-1:0]               r_last;       // most recently served requester
  logic [IDX_W-1:0]               r_gidx;       // index of the current owner
  logic [GAP_W-1:0]               r_gap_cnt;    // FETCH cycles without a byte
  logic                           r_last_flag;  // byte in flight ends the frame

  logic                           w_pick_found;
  logic [IDX_W-1:0]               w_pick_idx;
  logic                           w_hs;
  logic [P_UART_DATA_WIDTH-1:0]   w_sel_data;

  // Round-robin pick: first valid requester after r_last, with wrap-around.
  // The loop runs from the farthest candidate to the nearest so the nearest
  // valid one is the last assignment and wins.
  always_comb begin
    int v_idx;
    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    w_pick_found = 1'b0;
    w_pick_idx   = '0;
    v_idx        = 0;
    for (int i = P_REQ_NUM; i >= 1; i--) begin
      v_idx = int'(r_last) + i;
      if (v_idx >= P_REQ_NUM) v_idx = v_idx - P_REQ_NUM;
      if (i_req_valid[v_idx]) begin
        w_pick_found = 1'b1;
        w_pick_idx   = IDX_W'(v_idx);
      end
    end
  end

  // Ready is offered only to the owner, and only while a byte is wanted.
  always_comb begin
    o_req_ready = '0;
    if (r_state == ST_FETCH) o_req_ready = i_req_valid & o_grant;
  end

  assign w_hs       = |o_req_ready;
  assign w_sel_data = i_req_data[r_gidx*P_UART_DATA_WIDTH +: P_UART_DATA_WIDTH];
  assign o_tx_valid = (r_state == ST_ISSUE) && i_tx_ready;
  assign o_busy     = (r_state != ST_IDLE);

  // Arbitration FSM: grant, fetch one byte, hand it to the driver, wait for
  // the driver to take it and finish, then fetch the next or release.
  always_ff @(posedge w_user_clk or posedge w_user_rst) begin
    if (w_user_rst) begin
      r_state       <= ST_IDLE;
      o_grant       <= '0;
      r_last        <= IDX_W'(P_REQ_NUM - 1);
      r_gidx        <= '0;
      r_gap_cnt     <= '0;
      o_tx_data     <= '0;
      r_last_flag   <= 1'b0;
      o_frame_abort <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every branch
      // reads the values from before this clock edge.
      o_frame_abort <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_pick_found) begin
            o_grant   <= {{(P_REQ_NUM-1){1'b0}}, 1'b1} << w_pick_idx;
            r_gidx    <= w_pick_idx;
            r_gap_cnt <= '0;
            r_state   <= ST_FETCH;
          end
        end

        ST_FETCH: begin
          if (w_hs) begin
            o_tx_data   <= w_sel_data;
            r_last_flag <= i_req_last[r_gidx];
            r_gap_cnt   <= '0;
            r_state     <= ST_ISSUE;
          end else if (r_gap_cnt == GAP_W'(P_GAP_TIMEOUT - 1)) begin
            // Owner stalled mid-frame: revoke and let others in.
            o_frame_abort <= 1'b1;
            r_last        <= r_gidx;
            o_grant       <= '0;
            r_gap_cnt     <= '0;
            r_state       <= ST_IDLE;
          end else begin
            // Never passes P_GAP_TIMEOUT-1, the branch above catches it.
            r_gap_cnt <= r_gap_cnt + GAP_W'(1);
          end
        end

        ST_ISSUE: begin
          if (i_tx_ready) r_state <= ST_WAIT_LOW;
        end

        ST_WAIT_LOW: begin
          if (!i_tx_ready) r_state <= ST_WAIT_HIGH;
        end

        ST_WAIT_HIGH: begin
          if (i_tx_ready) begin
            if (r_last_flag) begin
              r_last  <= r_gidx;
              o_grant <= '0;
              r_state <= ST_IDLE;
            end else begin
              r_state <= ST_FETCH;
            end
          end
        end

        default: begin
          o_grant <= '0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: four requesters fed from per-requester
// byte lists, a UART driver model that drops ready for a set number of cycles
// after each strobe, and checks at the falling clock edge.
module tb_uart_tx_arbiter;

  localparam int N = 4;
  localparam int W = 8;

  logic           w_user_clk = 1'b0;
  logic           w_user_rst;
  logic [N*W-1:0] i_req_data;
  logic [N-1:0]   i_req_valid;
  logic [N-1:0]   i_req_last;
  logic [N-1:0]   o_req_ready;
  logic [W-1:0]   o_tx_data;
  logic           o_tx_valid;
  logic           i_tx_ready;
  logic [N-1:0]   o_grant;
  logic           o_busy;
  logic           o_frame_abort;

  int tests = 0;
  int fails = 0;

  // Source byte lists: {last, data}
  logic [8:0] src_mem [N][16];
  int         head [N];
  int         tail [N];

  // Recorded strobes
  logic [W-1:0] strobe_d [128];
  logic [N-1:0] strobe_g [128];
  int           n_strobe = 0;
  int           hold_cycles = 2;

  int bad_strobe = 0;
  int bad_ready  = 0;
  int abort_cnt  = 0;

  uart_tx_arbiter #(
    .P_REQ_NUM(N),
    .P_UART_DATA_WIDTH(W),
    .P_GAP_TIMEOUT(8)
  ) dut (
    .w_user_clk   (w_user_clk),
    .w_user_rst   (w_user_rst),
    .i_req_data   (i_req_data),
    .i_req_valid  (i_req_valid),
    .i_req_last   (i_req_last),
    .o_req_ready  (o_req_ready),
    .o_tx_data    (o_tx_data),
    .o_tx_valid   (o_tx_valid),
    .i_tx_ready   (i_tx_ready),
    .o_grant      (o_grant),
    .o_busy       (o_busy),
    .o_frame_abort(o_frame_abort)
  );

  always #5 w_user_clk = ~w_user_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int k, input logic [7:0] d, input logic l);
    src_mem[k][tail[k]] = {l, d};
    tail[k]++;
  endtask

  function automatic bit queues_empty();
    for (int k = 0; k < N; k++) if (head[k] != tail[k]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic wait_strobes(input string tag, input int n);
    int cyc;
    cyc = 0;
    while (n_strobe < n && cyc < 2000) begin
      @(negedge w_user_clk);
      cyc++;
    end
    check({tag, "_strobe_timeout"}, 32'(n_strobe >= n), 32'd1);
  endtask

  task automatic wait_idle(input string tag);
    int cyc;
    cyc = 0;
    @(negedge w_user_clk);
    while (!(o_busy == 1'b0 && queues_empty() && i_tx_ready == 1'b1) && cyc < 2000) begin
      @(negedge w_user_clk);
      cyc++;
    end
    check({tag, "_idle_timeout"}, 32'(cyc < 2000), 32'd1);
  endtask

  task automatic wait_ready_level(input string tag, input logic lvl);
    int cyc;
    cyc = 0;
    @(negedge w_user_clk);
    while (i_tx_ready !== lvl && cyc < 2000) begin
      @(negedge w_user_clk);
      cyc++;
    end
    check({tag, "_ready_timeout"}, 32'(cyc < 2000), 32'd1);
  endtask

  // Requester model: present the head byte of each list, advance on handshake.
  initial begin
    logic [N-1:0] hs;
    i_req_valid = '0;
    i_req_data  = '0;
    i_req_last  = '0;
    for (int k = 0; k < N; k++) begin
      head[k] = 0;
      tail[k] = 0;
    end
    forever begin
      @(negedge w_user_clk);
      hs = o_req_ready & i_req_valid;
      @(posedge w_user_clk);
      #1;
      for (int k = 0; k < N; k++) begin
        if (hs[k] && head[k] < tail[k]) head[k]++;
        if (head[k] < tail[k]) begin
          i_req_valid[k]       = 1'b1;
          i_req_data[k*W +: W] = src_mem[k][head[k]][7:0];
          i_req_last[k]        = src_mem[k][head[k]][8];
        end else begin
          i_req_valid[k] = 1'b0;
          i_req_last[k]  = 1'b0;
        end
      end
    end
  end

  // UART driver model: records each strobe, then is busy for hold_cycles.
  initial begin
    i_tx_ready = 1'b1;
    forever begin
      @(negedge w_user_clk);
      if (o_tx_valid === 1'b1 && !w_user_rst) begin
        strobe_d[n_strobe] = o_tx_data;
        strobe_g[n_strobe] = o_grant;
        n_strobe++;
        @(posedge w_user_clk);
        #1 i_tx_ready = 1'b0;
        repeat (hold_cycles) @(posedge w_user_clk);
        #1 i_tx_ready = 1'b1;
      end
    end
  end

  // Protocol watchers.
  initial begin
    forever begin
      @(negedge w_user_clk);
      if (!w_user_rst) begin
        if (o_tx_valid && !i_tx_ready) bad_strobe++;
        if ((o_req_ready & ~o_grant) != '0) bad_ready++;
        if (o_frame_abort) abort_cnt++;
      end
    end
  end

  // Watchdog.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    w_user_rst = 1'b1;
    repeat (3) @(negedge w_user_clk);

    // Reset state
    check("rst_grant", 32'(o_grant), 32'h0);
    check("rst_ready", 32'(o_req_ready), 32'h0);
    check("rst_tx_valid", 32'(o_tx_valid), 32'h0);
    check("rst_tx_data", 32'(o_tx_data), 32'h0);
    check("rst_busy", 32'(o_busy), 32'h0);
    check("rst_abort", 32'(o_frame_abort), 32'h0);
    w_user_rst = 1'b0;
    repeat (2) @(negedge w_user_clk);

    // Single frame from requester 2, with first-byte latency
    base = n_strobe;
    push(2, 8'hA1, 1'b0);
    push(2, 8'hA2, 1'b0);
    push(2, 8'hA3, 1'b1);
    begin
      int cyc;
      cyc = 0;
      do begin
        @(posedge w_user_clk);
        #2;
        cyc++;
      end while (!i_req_valid[2] && cyc < 10);
    end
    @(negedge w_user_clk);
    check("sf_c0_grant", 32'(o_grant), 32'h0);
    @(negedge w_user_clk);
    check("sf_c1_grant", 32'(o_grant), 32'h4);
    check("sf_c1_ready", 32'(o_req_ready), 32'h4);
    @(negedge w_user_clk);
    check("sf_c2_tx_valid", 32'(o_tx_valid), 32'h1);
    check("sf_c2_tx_data", 32'(o_tx_data), 32'hA1);
    wait_strobes("sf", base + 3);
    wait_idle("sf");
    check("sf_byte0", 32'(strobe_d[base]), 32'hA1);
    check("sf_byte1", 32'(strobe_d[base+1]), 32'hA2);
    check("sf_byte2", 32'(strobe_d[base+2]), 32'hA3);
    check("sf_grant0", 32'(strobe_g[base]), 32'h4);
    check("sf_grant2", 32'(strobe_g[base+2]), 32'h4);
    check("sf_grant_released", 32'(o_grant), 32'h0);
    check("sf_count", 32'(n_strobe - base), 32'd3);

    // Round robin from reset: 0, 1, 3; requester 0 re-armed while 3 owns
    w_user_rst = 1'b1;
    @(negedge w_user_clk);
    w_user_rst = 1'b0;
    @(negedge w_user_clk);
    base = n_strobe;
    push(0, 8'h10, 1'b1);
    push(1, 8'h11, 1'b1);
    push(3, 8'h13, 1'b1);
    begin
      int cyc;
      cyc = 0;
      while (o_grant != 4'b1000 && cyc < 2000) begin
        @(negedge w_user_clk);
        cyc++;
      end
      check("rr_grant3_seen", 32'(o_grant), 32'h8);
    end
    push(0, 8'h20, 1'b1);
    wait_strobes("rr", base + 4);
    wait_idle("rr");
    check("rr_byte0", 32'(strobe_d[base]), 32'h10);
    check("rr_byte1", 32'(strobe_d[base+1]), 32'h11);
    check("rr_byte2", 32'(strobe_d[base+2]), 32'h13);
    check("rr_byte3", 32'(strobe_d[base+3]), 32'h20);
    check("rr_grant3", 32'(strobe_g[base+3]), 32'h1);

    // Frame lock: requester 0 arrives after byte 1 of requester 1
    base = n_strobe;
    push(1, 8'h31, 1'b0);
    push(1, 8'h32, 1'b0);
    push(1, 8'h33, 1'b0);
    push(1, 8'h34, 1'b1);
    wait_strobes("fl_first", base + 1);
    push(0, 8'h40, 1'b1);
    wait_strobes("fl", base + 5);
    wait_idle("fl");
    check("fl_byte0", 32'(strobe_d[base]), 32'h31);
    check("fl_byte1", 32'(strobe_d[base+1]), 32'h32);
    check("fl_byte2", 32'(strobe_d[base+2]), 32'h33);
    check("fl_byte3", 32'(strobe_d[base+3]), 32'h34);
    check("fl_byte4", 32'(strobe_d[base+4]), 32'h40);
    check("fl_owner_byte3", 32'(strobe_g[base+3]), 32'h2);
    check("fl_ready_leak", 32'(bad_ready), 32'd0);

    // Gap timeout: requester 0 sends one non-last byte, then goes quiet
    base = n_strobe;
    push(0, 8'h50, 1'b0);
    begin
      int cyc;
      cyc = 0;
      while (o_grant != 4'b0001 && cyc < 2000) begin
        @(negedge w_user_clk);
        cyc++;
      end
      check("gap_grant0_seen", 32'(o_grant), 32'h1);
    end
    push(1, 8'h51, 1'b1);
    wait_strobes("gap_byte", base + 1);
    wait_ready_level("gap_low", 1'b0);
    wait_ready_level("gap_high", 1'b1);
    // Now in the last WAIT_HIGH cycle; FETCH occupies the next 8 cycles.
    for (int i = 2; i <= 9; i++) begin
      @(negedge w_user_clk);
      check($sformatf("gap_hold_abort_%0d", i), 32'(o_frame_abort), 32'h0);
      check($sformatf("gap_hold_grant_%0d", i), 32'(o_grant), 32'h1);
    end
    @(negedge w_user_clk);
    check("gap_abort_pulse", 32'(o_frame_abort), 32'h1);
    check("gap_grant_cleared", 32'(o_grant), 32'h0);
    @(negedge w_user_clk);
    check("gap_abort_end", 32'(o_frame_abort), 32'h0);
    check("gap_next_grant", 32'(o_grant), 32'h2);
    wait_strobes("gap_next", base + 2);
    wait_idle("gap");
    check("gap_byte0", 32'(strobe_d[base]), 32'h50);
    check("gap_byte1", 32'(strobe_d[base+1]), 32'h51);
    check("gap_abort_count", 32'(abort_cnt), 32'd1);

    // Slow ready: driver busy for 100 cycles after each strobe
    hold_cycles = 100;
    base = n_strobe;
    push(3, 8'h61, 1'b0);
    push(3, 8'h62, 1'b0);
    push(3, 8'h63, 1'b1);
    wait_strobes("slow", base + 3);
    wait_idle("slow");
    hold_cycles = 2;
    repeat (5) @(negedge w_user_clk);
    check("slow_count", 32'(n_strobe - base), 32'd3);
    check("slow_byte0", 32'(strobe_d[base]), 32'h61);
    check("slow_byte2", 32'(strobe_d[base+2]), 32'h63);
    check("slow_no_strobe_while_busy", 32'(bad_strobe), 32'd0);

    // Reset in WAIT_LOW, then a fresh round starting at requester 0
    base = n_strobe;
    push(2, 8'h71, 1'b0);
    push(2, 8'h72, 1'b1);
    wait_strobes("mr", base + 1);
    @(posedge w_user_clk);
    #3;
    w_user_rst = 1'b1;
    #1;
    check("mr_grant", 32'(o_grant), 32'h0);
    check("mr_ready", 32'(o_req_ready), 32'h0);
    check("mr_tx_valid", 32'(o_tx_valid), 32'h0);
    check("mr_tx_data", 32'(o_tx_data), 32'h0);
    check("mr_busy", 32'(o_busy), 32'h0);
    check("mr_abort", 32'(o_frame_abort), 32'h0);
    for (int k = 0; k < N; k++) head[k] = tail[k];
    repeat (3) @(negedge w_user_clk);
    w_user_rst = 1'b0;
    wait_ready_level("mr_rel", 1'b1);
    repeat (2) @(negedge w_user_clk);
    base = n_strobe;
    push(3, 8'h83, 1'b1);
    push(0, 8'h80, 1'b1);
    wait_strobes("mr", base + 2);
    wait_idle("mr");
    check("mr_byte0", 32'(strobe_d[base]), 32'h80);
    check("mr_grant0", 32'(strobe_g[base]), 32'h1);
    check("mr_byte1", 32'(strobe_d[base+1]), 32'h83);
    check("mr_count", 32'(n_strobe - base), 32'd2);

    check("final_no_strobe_while_busy", 32'(bad_strobe), 32'd0);
    check("final_ready_only_to_owner", 32'(bad_ready), 32'd0);
    check("final_abort_count", 32'(abort_cnt), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
